// File: rtl/fsm.sv
// Datapath sequencer control FSM. It maps the current state, the instruction
// opcode and the new-instruction strobe to the next state and the busy/done flags.
module fsm (
  input  logic        clk,
  input  logic        resetn,
  input  logic [4:0]  cur,
  input  logic [24:0] func,
  input  logic        new_func,
  output logic [4:0]  next,
  output logic [4:0]  state,
  output logic        busy,
  output logic        done
);

  typedef enum logic [4:0] {
    S_WAIT   = 5'b00000,
    S_DECODE = 5'b00001,
    S_LOAD   = 5'b00010,
    S_MOVE   = 5'b00011,
    S_ADD1   = 5'b00100,
    S_ADD2   = 5'b00101,
    S_ADD3   = 5'b00110,
    S_XOR1   = 5'b00111,
    S_XOR2   = 5'b01000,
    S_XOR3   = 5'b01001
  } state_t;

  typedef enum logic [2:0] {
    OP_LOAD = 3'b000,
    OP_MOVE = 3'b001,
    OP_ADD  = 3'b010,
    OP_XOR  = 3'b011
  } opcode_t;

  // new_func is a level-sensitive strobe: it is only looked at while cur is WAIT,
  // and every cycle it is high there starts a decode (no edge detection).
  logic [2:0] opcode;
  logic       operand_unused;
  state_t     next_s;

  assign opcode         = func[24:22];
  assign operand_unused = ^func[21:0];

  always_comb begin
    next_s = S_WAIT;
    busy   = 1'b0;
    done   = 1'b0;
    case (cur)
      S_WAIT: begin
        if (new_func) next_s = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OP_LOAD: next_s = S_LOAD;
          OP_MOVE: next_s = S_MOVE;
          OP_ADD:  next_s = S_ADD1;
          OP_XOR:  next_s = S_XOR1;
          default: next_s = S_WAIT;
        endcase
      end
      S_LOAD, S_MOVE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      S_ADD1: begin
        busy   = 1'b1;
        next_s = S_ADD2;
      end
      S_ADD2: begin
        busy   = 1'b1;
        next_s = S_ADD3;
      end
      S_ADD3: begin
        busy = 1'b1;
        done = 1'b1;
      end
      S_XOR1: begin
        busy   = 1'b1;
        next_s = S_XOR2;
      end
      S_XOR2: begin
        busy   = 1'b1;
        next_s = S_XOR3;
      end
      S_XOR3: begin
        busy = 1'b1;
        done = 1'b1;
      end
      // Illegal encodings fall back to WAIT with both flags low.
      default: next_s = S_WAIT;
    endcase
  end

  assign next = next_s;

  always_ff @(posedge clk) begin
    if (!resetn) state <= S_WAIT;
    else         state <= next;
  end

endmodule

// File: tb/tb_fsm.sv
// Directed bench for fsm: open-loop decode checks with cur forced, then closed-loop
// sequences with cur fed from state, including a reset in the middle of an op.
module tb_fsm;

  logic        clk;
  logic        resetn;
  logic [4:0]  cur;
  logic [24:0] func;
  logic        new_func;
  logic [4:0]  next;
  logic [4:0]  state;
  logic        busy;
  logic        done;

  logic [4:0]  cur_drv;
  logic        closed_loop;
  int          checks;
  int          failures;

  localparam logic [24:0] F_LOAD = 25'h0048000;
  localparam logic [24:0] F_MOVE = 25'h05A1234;
  localparam logic [24:0] F_ADD  = 25'h0800000;
  localparam logic [24:0] F_XOR  = 25'h0C1FFFF;
  localparam logic [24:0] F_RSV5 = 25'h1400000;
  localparam logic [24:0] F_RSV7 = 25'h1C00000;

  assign cur = closed_loop ? state : cur_drv;

  fsm dut (
    .clk      (clk),
    .resetn   (resetn),
    .cur      (cur),
    .func     (func),
    .new_func (new_func),
    .next     (next),
    .state    (state),
    .busy     (busy),
    .done     (done)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checker tasks
  task automatic chk5(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Open-loop probe: force cur/func/new_func and check the combinational outputs.
  task automatic probe(input string tag, input logic [4:0] c, input logic [24:0] f,
                       input logic nf, input logic [4:0] exp_next,
                       input logic exp_busy, input logic exp_done);
    cur_drv  = c;
    func     = f;
    new_func = nf;
    #1;
    chk5({tag, "_next"}, next, exp_next);
    chk1({tag, "_busy"}, busy, exp_busy);
    chk1({tag, "_done"}, done, exp_done);
  endtask

  // Advance one clock, then check the registered state away from the edge.
  task automatic step(input string tag, input logic [4:0] exp_state);
    @(posedge clk);
    #1;
    chk5(tag, state, exp_state);
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    closed_loop = 1'b0;
    cur_drv     = 5'b00000;
    func        = '0;
    new_func    = 1'b0;
    resetn      = 1'b0;

    // Reset
    @(posedge clk);
    @(posedge clk);
    #1;
    chk5("reset_state", state, 5'b00000);
    resetn = 1'b1;

    // Open-loop decode table
    probe("wait_idle",    5'b00000, '0,     1'b0, 5'b00000, 1'b0, 1'b0);
    probe("wait_strobe",  5'b00000, '0,     1'b1, 5'b00001, 1'b0, 1'b0);
    probe("decode_load",  5'b00001, F_LOAD, 1'b0, 5'b00010, 1'b0, 1'b0);
    probe("load_last",    5'b00010, F_LOAD, 1'b0, 5'b00000, 1'b1, 1'b1);
    probe("decode_move",  5'b00001, F_MOVE, 1'b1, 5'b00011, 1'b0, 1'b0);
    probe("move_last",    5'b00011, F_MOVE, 1'b1, 5'b00000, 1'b1, 1'b1);
    probe("decode_add",   5'b00001, F_ADD,  1'b0, 5'b00100, 1'b0, 1'b0);
    probe("decode_xor",   5'b00001, F_XOR,  1'b0, 5'b00111, 1'b0, 1'b0);
    probe("decode_rsv5",  5'b00001, F_RSV5, 1'b0, 5'b00000, 1'b0, 1'b0);
    probe("decode_rsv7",  5'b00001, F_RSV7, 1'b1, 5'b00000, 1'b0, 1'b0);
    probe("add2_hold_nf", 5'b00101, F_XOR,  1'b1, 5'b00110, 1'b1, 1'b0);
    probe("xor2_step",    5'b01000, F_LOAD, 1'b1, 5'b01001, 1'b1, 1'b0);
    probe("illegal_0a",   5'b01010, '0,     1'b1, 5'b00000, 1'b0, 1'b0);
    probe("illegal_1f",   5'b11111, F_ADD,  1'b1, 5'b00000, 1'b0, 1'b0);

    // Closed loop ADD with a one-cycle strobe
    closed_loop = 1'b1;
    func        = F_ADD;
    new_func    = 1'b1;
    #1;
    chk5("add_wait_next", next, 5'b00001);
    step("add_s1", 5'b00001);
    new_func = 1'b0;
    step("add_s2", 5'b00100);
    step("add_s3", 5'b00101);
    step("add_s4", 5'b00110);
    #1;
    chk1("add3_done", done, 1'b1);
    step("add_s5", 5'b00000);
    step("add_idle", 5'b00000);

    // Closed loop XOR with new_func held high through the op
    func     = F_XOR;
    new_func = 1'b1;
    step("xor_s1", 5'b00001);
    step("xor_s2", 5'b00111);
    step("xor_s3", 5'b01000);
    step("xor_s4", 5'b01001);
    #1;
    chk1("xor3_done", done, 1'b1);
    step("xor_s5", 5'b00000);
    new_func = 1'b0;
    step("xor_idle", 5'b00000);

    // Reset abandoned mid-op in XOR2
    new_func = 1'b1;
    step("rst_s1", 5'b00001);
    new_func = 1'b0;
    step("rst_s2", 5'b00111);
    step("rst_s3", 5'b01000);
    resetn = 1'b0;
    step("rst_applied", 5'b00000);
    resetn = 1'b1;
    step("rst_after", 5'b00000);
    #1;
    chk1("rst_busy", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog
  initial begin
    #20000;
    failures++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
